// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state type and default geometry for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_ADDR  = 4;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client request/grant bus plus the RAM pin bundle of the arbiter.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR  = DEF_ADDR,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
);
    logic                  init_req;
    logic                  busy;
    logic [NREQ-1:0]       wr_req;
    logic [NREQ*ADDR-1:0]  wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       wr_gnt;
    logic [NREQ-1:0]       rd_req;
    logic [NREQ*ADDR-1:0]  rd_addr;
    logic [NREQ-1:0]       rd_gnt;
    logic                  rd_valid;
    logic [IDW-1:0]        rd_id;
    logic [WIDTH-1:0]      rd_data;
    logic                  ram_we;
    logic [ADDR-1:0]       ram_wr_addr;
    logic [WIDTH-1:0]      ram_wr_data;
    logic                  ram_re;
    logic [ADDR-1:0]       ram_rd_addr;
    logic [WIDTH-1:0]      ram_d_out;

    modport slave (
        input  init_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_d_out,
        output busy, wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
               ram_we, ram_wr_addr, ram_wr_data, ram_re, ram_rd_addr
    );

    modport master (
        output init_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_d_out,
        input  busy, wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
               ram_we, ram_wr_addr, ram_wr_data, ram_re, ram_rd_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts at ptr and wraps.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);
    logic [IDW-1:0] j;

    // Scan from the farthest offset down so the closest asserted request to ptr wins last.
    always_comb begin
        j = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % N);
            if (req[j]) gnt_idx = j;
        end
        any = |req;
        gnt = any ? N'(1) << gnt_idx : '0;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: zero-fills a dual-port RAM, then round-robin shares its write
// and read ports between NREQ requesters, tagging read data with the requester id.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = $clog2(DEPTH),
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic               clk,
    input logic               rst_n,
    ram_port_arbiter_if.slave bus
);
    state_t          state, state_nx;
    logic [ADDR-1:0] clr_cnt;
    logic [IDW-1:0]  wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic            wr_any, rd_any, en;

    // Grants exist only in RUN and are suppressed on the cycle init_req is seen.
    assign en = (state == RUN) && !bus.init_req;

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .req(bus.wr_req & {NREQ{en}}), .ptr(wr_ptr),
        .gnt(bus.wr_gnt), .gnt_idx(wr_idx), .any(wr_any)
    );

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .req(bus.rd_req & {NREQ{en}}), .ptr(rd_ptr),
        .gnt(bus.rd_gnt), .gnt_idx(rd_idx), .any(rd_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            clr_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_id    <= '0;
        end else begin
            state        <= state_nx;
            clr_cnt      <= (state == INIT) ? clr_cnt + 1'b1 : '0;
            wr_ptr       <= wr_any ? IDW'((int'(wr_idx) + 1) % NREQ) : wr_ptr;
            rd_ptr       <= rd_any ? IDW'((int'(rd_idx) + 1) % NREQ) : rd_ptr;
            bus.rd_valid <= rd_any;
            bus.rd_id    <= rd_any ? rd_idx : bus.rd_id;
        end
    end

    always_comb
        state_nx = (state == INIT) ? ((clr_cnt == ADDR'(DEPTH - 1)) ? RUN : INIT)
                                   : (bus.init_req ? INIT : RUN);

    always_comb begin
        bus.busy        = state == INIT;
        bus.ram_we      = (state == INIT) || wr_any;
        bus.ram_wr_addr = (state == INIT) ? clr_cnt : bus.wr_addr[wr_idx*ADDR +: ADDR];
        bus.ram_wr_data = (state == INIT) ? '0 : bus.wr_data[wr_idx*WIDTH +: WIDTH];
        bus.ram_re      = rd_any;
        bus.ram_rd_addr = bus.rd_addr[rd_idx*ADDR +: ADDR];
        bus.rd_data     = bus.ram_d_out;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scenario tasks plus randomized traffic checked against a
// queue-free behavioural model (shadow memory + round-robin pointers).
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    logic [7:0] mem    [16];
    logic [7:0] shadow [16];
    logic [3:0] wa [4];
    logic [7:0] wd [4];
    logic [3:0] ra [4];
    int mp_wr = 0;
    int mp_rd = 0;

    ram_port_arbiter_if bus ();
    ram_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural RAM with registered, read-before-write output.
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_d_out <= mem[bus.ram_rd_addr];
        if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] oh(int e);
        return (e < 0) ? 4'b0 : 4'(1 << e);
    endfunction

    task automatic drive(logic init, logic [3:0] wreq, logic [3:0] rreq);
        logic [15:0] a, b;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a[i*4 +: 4] = wa[i];
            b[i*4 +: 4] = ra[i];
            d[i*8 +: 8] = wd[i];
        end
        bus.init_req = init;
        bus.wr_req   = wreq;
        bus.rd_req   = rreq;
        bus.wr_addr  = a;
        bus.rd_addr  = b;
        bus.wr_data  = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin wa[i] = 0; wd[i] = 0; ra[i] = 0; end
        drive(0, 0, 0);
        rst_n = 0;
        @(negedge clk); #1;
        total++;
        if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_id !== 2'd0 || bus.ram_wr_addr !== 4'd0)
            begin bad++; $display("FAIL reset_state: busy=%b rd_valid=%b rd_id=%0d addr=%0d want 1 0 0 0", bus.busy, bus.rd_valid, bus.rd_id, bus.ram_wr_addr); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1;
            #1;
            total++;
            if (bus.busy !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wr_addr !== 4'(c) || bus.ram_wr_data !== 8'h00 || bus.ram_re !== 1'b0 || bus.wr_gnt !== 4'b0 || bus.rd_gnt !== 4'b0)
                begin bad++; $display("FAIL fill_%0d: busy=%b we=%b addr=%0d data=%h re=%b want 1 1 %0d 00 0", c, bus.busy, bus.ram_we, bus.ram_wr_addr, bus.ram_wr_data, bus.ram_re, c); end
        end
        @(negedge clk); #1;
        total++;
        if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0)
            begin bad++; $display("FAIL fill_done: busy=%b we=%b want 0 0", bus.busy, bus.ram_we); end
        for (int i = 0; i < 16; i++) shadow[i] = 0;
        mp_wr = 0;
        mp_rd = 0;
    endtask

    task automatic test_round_robin();
        int e;
        for (int i = 0; i < 4; i++) begin wa[i] = 4'(8 + i); wd[i] = 8'($urandom); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            drive(0, 4'hF, 0);
            #1;
            e = pick(4'hF, mp_wr);
            total++;
            if (bus.wr_gnt !== 4'(1 << (n % 4)) || bus.wr_gnt !== oh(e) || bus.ram_we !== 1'b1 || bus.ram_wr_addr !== wa[e] || bus.ram_wr_data !== wd[e])
                begin bad++; $display("FAIL rr_%0d: gnt=%b addr=%0d data=%h want %b %0d %h", n, bus.wr_gnt, bus.ram_wr_addr, bus.ram_wr_data, oh(n % 4), wa[e], wd[e]); end
            shadow[wa[e]] = wd[e];
            mp_wr = (e + 1) % 4;
        end
        @(negedge clk);
        drive(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[wa[i]] !== wd[i])
                begin bad++; $display("FAIL rr_mem_%0d: got %h want %h", i, mem[wa[i]], wd[i]); end
        end
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        wa[1] = 4'd3; wd[1] = 8'hA5;
        drive(0, 4'b0010, 0);
        #1;
        total++;
        if (bus.wr_gnt !== 4'b0010 || bus.ram_wr_addr !== 4'd3 || bus.ram_wr_data !== 8'hA5)
            begin bad++; $display("FAIL wr_a5: gnt=%b addr=%0d data=%h want 0010 3 a5", bus.wr_gnt, bus.ram_wr_addr, bus.ram_wr_data); end
        shadow[3] = 8'hA5;
        mp_wr = 2;
        @(negedge clk);
        ra[2] = 4'd3;
        drive(0, 0, 4'b0100);
        #1;
        total++;
        if (bus.rd_gnt !== 4'b0100 || bus.ram_re !== 1'b1 || bus.ram_rd_addr !== 4'd3 || bus.rd_valid !== 1'b0)
            begin bad++; $display("FAIL rd_gnt: gnt=%b re=%b addr=%0d valid=%b want 0100 1 3 0", bus.rd_gnt, bus.ram_re, bus.ram_rd_addr, bus.rd_valid); end
        mp_rd = 3;
        @(negedge clk);
        drive(0, 0, 0);
        #1;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_id !== 2'd2 || bus.rd_data !== 8'hA5 || bus.rd_gnt !== 4'b0)
            begin bad++; $display("FAIL rd_ret: valid=%b id=%0d data=%h want 1 2 a5", bus.rd_valid, bus.rd_id, bus.rd_data); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wa[0] = 4'd5; wd[0] = 8'h11;
        drive(0, 4'b0001, 0);
        @(negedge clk);
        wd[0] = 8'h3C; ra[3] = 4'd5;
        drive(0, 4'b0001, 4'b1000);
        #1;
        total++;
        if (bus.wr_gnt !== 4'b0001 || bus.rd_gnt !== 4'b1000)
            begin bad++; $display("FAIL coll_gnt: wr=%b rd=%b want 0001 1000", bus.wr_gnt, bus.rd_gnt); end
        @(negedge clk);
        drive(0, 0, 4'b1000);
        #1;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_id !== 2'd3 || bus.rd_data !== 8'h11)
            begin bad++; $display("FAIL coll_old: valid=%b id=%0d data=%h want 1 3 11", bus.rd_valid, bus.rd_id, bus.rd_data); end
        @(negedge clk);
        drive(0, 0, 0);
        #1;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C)
            begin bad++; $display("FAIL coll_new: valid=%b data=%h want 1 3c", bus.rd_valid, bus.rd_data); end
        shadow[5] = 8'h3C;
        mp_wr = 1;
        mp_rd = 0;
    endtask

    task automatic test_random();
        logic [3:0] pw, pr;
        logic ev;
        int eid, ew, er;
        logic [7:0] ed;
        pw = 0; pr = 0; ev = 0; eid = 0; ed = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pw[i] && $urandom_range(0, 2) != 0) begin pw[i] = 1; wa[i] = 4'($urandom); wd[i] = 8'($urandom); end
                if (!pr[i] && $urandom_range(0, 2) != 0) begin pr[i] = 1; ra[i] = 4'($urandom); end
            end
            drive(0, pw, pr);
            #1;
            ew = pick(pw, mp_wr);
            er = pick(pr, mp_rd);
            total++;
            if (bus.wr_gnt !== oh(ew) || bus.ram_we !== (ew >= 0))
                begin bad++; $display("FAIL rnd_wgnt_%0d: gnt=%b we=%b want %b", n, bus.wr_gnt, bus.ram_we, oh(ew)); end
            total++;
            if (bus.rd_gnt !== oh(er) || bus.ram_re !== (er >= 0))
                begin bad++; $display("FAIL rnd_rgnt_%0d: gnt=%b re=%b want %b", n, bus.rd_gnt, bus.ram_re, oh(er)); end
            if (ew >= 0) begin
                total++;
                if (bus.ram_wr_addr !== wa[ew] || bus.ram_wr_data !== wd[ew])
                    begin bad++; $display("FAIL rnd_wr_%0d: addr=%0d data=%h want %0d %h", n, bus.ram_wr_addr, bus.ram_wr_data, wa[ew], wd[ew]); end
            end
            if (er >= 0) begin
                total++;
                if (bus.ram_rd_addr !== ra[er])
                    begin bad++; $display("FAIL rnd_rdaddr_%0d: got %0d want %0d", n, bus.ram_rd_addr, ra[er]); end
            end
            total++;
            if (bus.rd_valid !== ev || (ev && (bus.rd_id !== 2'(eid) || bus.rd_data !== ed)))
                begin bad++; $display("FAIL rnd_ret_%0d: valid=%b id=%0d data=%h want %b %0d %h", n, bus.rd_valid, bus.rd_id, bus.rd_data, ev, eid, ed); end
            ev = er >= 0;
            if (ev) begin eid = er; ed = shadow[ra[er]]; pr[er] = 0; mp_rd = (er + 1) % 4; end
            if (ew >= 0) begin shadow[wa[ew]] = wd[ew]; pw[ew] = 0; mp_wr = (ew + 1) % 4; end
        end
        @(negedge clk);
        drive(0, 0, 0);
        #1;
        total++;
        if (bus.rd_valid !== ev || (ev && (bus.rd_id !== 2'(eid) || bus.rd_data !== ed)))
            begin bad++; $display("FAIL rnd_last: valid=%b id=%0d data=%h want %b %0d %h", bus.rd_valid, bus.rd_id, bus.rd_data, ev, eid, ed); end
    endtask

    task automatic test_init_req();
        logic [3:0] a;
        logic [7:0] d;
        int ew, er;
        @(negedge clk);
        a = 4'($urandom);
        ra[1] = a;
        d = shadow[a];
        drive(0, 0, 4'b0010);
        #1;
        mp_rd = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin wa[i] = 4'($urandom); wd[i] = 8'($urandom); ra[i] = 4'($urandom); end
        drive(1, 4'hF, 4'hF);
        #1;
        total++;
        if (bus.wr_gnt !== 4'b0 || bus.rd_gnt !== 4'b0 || bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL init_suppress: wgnt=%b rgnt=%b we=%b re=%b busy=%b want 0 0 0 0 0", bus.wr_gnt, bus.rd_gnt, bus.ram_we, bus.ram_re, bus.busy); end
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_id !== 2'd1 || bus.rd_data !== d)
            begin bad++; $display("FAIL init_last_rd: valid=%b id=%0d data=%h want 1 1 %h", bus.rd_valid, bus.rd_id, bus.rd_data, d); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            drive(c == 5, 4'hF, 4'hF);
            #1;
            total++;
            if (bus.busy !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wr_addr !== 4'(c) || bus.ram_wr_data !== 8'h00 || bus.wr_gnt !== 4'b0 || bus.rd_gnt !== 4'b0 || bus.rd_valid !== 1'b0)
                begin bad++; $display("FAIL refill_%0d: busy=%b we=%b addr=%0d data=%h wg=%b rg=%b valid=%b want addr %0d", c, bus.busy, bus.ram_we, bus.ram_wr_addr, bus.ram_wr_data, bus.wr_gnt, bus.rd_gnt, bus.rd_valid, c); end
        end
        for (int i = 0; i < 16; i++) shadow[i] = 0;
        @(negedge clk);
        drive(0, 4'hF, 4'hF);
        #1;
        ew = pick(4'hF, mp_wr);
        er = pick(4'hF, mp_rd);
        total++;
        if (bus.busy !== 1'b0 || bus.wr_gnt !== oh(ew) || bus.rd_gnt !== oh(er))
            begin bad++; $display("FAIL ptr_kept: busy=%b wg=%b rg=%b want 0 %b %b", bus.busy, bus.wr_gnt, bus.rd_gnt, oh(ew), oh(er)); end
        shadow[wa[ew]] = wd[ew];
        mp_wr = (ew + 1) % 4;
        mp_rd = (er + 1) % 4;
        for (int n = 0; n <= 16; n++) begin
            @(negedge clk);
            if (n < 16) begin ra[n % 4] = 4'(n); drive(0, 0, oh(n % 4)); end
            else drive(0, 0, 0);
            #1;
            if (n > 0) begin
                total++;
                if (bus.rd_valid !== 1'b1 || bus.rd_id !== 2'((n - 1) % 4) || bus.rd_data !== shadow[n - 1])
                    begin bad++; $display("FAIL zero_rd_%0d: valid=%b id=%0d data=%h want 1 %0d %h", n - 1, bus.rd_valid, bus.rd_id, bus.rd_data, (n - 1) % 4, shadow[n - 1]); end
            end
            if (n < 16) mp_rd = (n % 4 + 1) % 4;
        end
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        drive(1, 0, 0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive(0, 0, 0);
            #1;
            total++;
            if (bus.busy !== 1'b1 || bus.ram_wr_addr !== 4'(c))
                begin bad++; $display("FAIL mid_fill_%0d: busy=%b addr=%0d want 1 %0d", c, bus.busy, bus.ram_wr_addr, c); end
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.ram_wr_addr !== 4'd7)
            begin bad++; $display("FAIL mid_at7: addr=%0d want 7", bus.ram_wr_addr); end
        rst_n = 0;
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.ram_wr_addr !== 4'd0 || bus.rd_valid !== 1'b0)
            begin bad++; $display("FAIL mid_reset: busy=%b addr=%0d valid=%b want 1 0 0", bus.busy, bus.ram_wr_addr, bus.rd_valid); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1;
            #1;
            total++;
            if (bus.busy !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wr_addr !== 4'(c))
                begin bad++; $display("FAIL restart_%0d: busy=%b we=%b addr=%0d want 1 1 %0d", c, bus.busy, bus.ram_we, bus.ram_wr_addr, c); end
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0)
            begin bad++; $display("FAIL restart_done: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_collision();
        test_random();
        test_init_req();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
